// File: rtl/multi_counter_strobe_pkg.sv
// Shared encodings for the multi-channel terminal-count strobe generator.
package multi_counter_strobe_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/counter_channel.sv
// One counter channel: IDLE/RUN FSM, terminal compare and delayed strobe pipeline.
module counter_channel
    import multi_counter_strobe_pkg::*;
#(
    parameter int WIDTH   = 25,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             load_oneshot,
    output logic             strobe,
    output logic             active,
    output logic [WIDTH-1:0] count
);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   counter;
    logic [WIDTH-1:0]   counter_next;
    logic [WIDTH-1:0]   counter_inc;
    logic [WIDTH-1:0]   terminal;
    logic [WIDTH-1:0]   terminal_next;
    logic               mode;
    logic               mode_next;
    logic               hit;
    // Stage 0 is the internal terminal strobe; the last stage drives the port.
    logic [LATENCY+1:0] strobe_pipe;

    assign counter_inc = counter + WIDTH'(1);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_next    = state;
        counter_next  = counter;
        terminal_next = terminal;
        mode_next     = mode;
        hit           = 1'b0;
        if (load) begin
            // A load overrides a coincident terminal event, so no strobe is raised.
            terminal_next = load_value;
            mode_next     = load_oneshot ? MODE_ONESHOT : MODE_PERIODIC;
            counter_next  = '0;
            state_next    = (load_value != '0) ? ST_RUN : ST_IDLE;
        end else if (state == ST_RUN && enable) begin
            if (counter_inc == terminal) begin
                counter_next = '0;
                hit          = 1'b1;
                if (mode == MODE_ONESHOT) begin
                    state_next = ST_IDLE;
                end
            end else begin
                counter_next = counter_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            counter     <= '0;
            terminal    <= '0;
            mode        <= MODE_PERIODIC;
            // NOTE: the strobe pipeline is reset too, so in-flight pulses die with reset.
            strobe_pipe <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state       <= state_next;
            counter     <= counter_next;
            terminal    <= terminal_next;
            mode        <= mode_next;
            strobe_pipe <= {strobe_pipe[LATENCY:0], hit};
        end
    end

    assign strobe = strobe_pipe[LATENCY+1];
    assign active = (state == ST_RUN);
    assign count  = counter;

endmodule

// File: rtl/multi_counter_strobe.sv
// Bank of independent terminal-count strobe channels sharing one load port.
module multi_counter_strobe
    import multi_counter_strobe_pkg::*;
#(
    parameter  int WIDTH    = 25,
    parameter  int CHANNELS = 4,
    parameter  int LATENCY  = 0,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [CH_W-1:0]           load_channel,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      load_oneshot,
    output logic [CHANNELS-1:0]       strobe,
    output logic [CHANNELS-1:0]       active,
    output logic [CHANNELS*WIDTH-1:0] count
);

    logic                load_accept;
    logic [CHANNELS-1:0] load_hit;

    assign load_accept = load_valid && load_ready;

    // One idle cycle after every accepted load paces loads to one per two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_ready <= 1'b1;
        end else begin
            load_ready <= !load_accept;
        end
    end

    // Out-of-range channel indices match no channel and are silently dropped.
    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        assign load_hit[n] = load_accept && (load_channel == CH_W'(n));

        counter_channel #(
            .WIDTH  (WIDTH),
            .LATENCY(LATENCY)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .enable      (enable[n]),
            .load        (load_hit[n]),
            .load_value  (load_value),
            .load_oneshot(load_oneshot),
            .strobe      (strobe[n]),
            .active      (active[n]),
            .count       (count[n*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_counter_strobe.sv
// Randomised and directed bench for multi_counter_strobe at three strobe latencies.
module tb_multi_counter_strobe;

    localparam int W    = 8;
    localparam int CH   = 5;
    localparam int CW   = 3;
    localparam int NI   = 3;
    localparam int MAXE = 4096;

    logic          clk;
    logic          rst;
    logic [CH-1:0] enable;
    logic          load_valid;
    logic [CW-1:0] load_channel;
    logic [W-1:0]  load_value;
    logic          load_oneshot;

    logic            ready_o  [NI];
    logic [CH-1:0]   strobe_o [NI];
    logic [CH-1:0]   active_o [NI];
    logic [CH*W-1:0] count_o  [NI];

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        multi_counter_strobe #(
            .WIDTH   (W),
            .CHANNELS(CH),
            .LATENCY ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .enable      (enable),
            .load_valid  (load_valid),
            .load_ready  (ready_o[g]),
            .load_channel(load_channel),
            .load_value  (load_value),
            .load_oneshot(load_oneshot),
            .strobe      (strobe_o[g]),
            .active      (active_o[g]),
            .count       (count_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: channel state as plain integers, strobes scheduled by absolute edge number.
    bit            m_run  [CH];
    int            m_cnt  [CH];
    int            m_term [CH];
    bit            m_os   [CH];
    bit            m_ready;
    bit            m_acc;
    int            edge_n;
    logic [CH-1:0] exp_str [NI][MAXE];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_run[c]  = 1'b0;
            m_cnt[c]  = 0;
            m_term[c] = 0;
            m_os[c]   = 1'b0;
        end
        m_ready = 1'b1;
        m_acc   = 1'b0;
        for (int g = 0; g < NI; g++)
            for (int e = edge_n; e < MAXE; e++)
                exp_str[g][e] = '0;
    endfunction

    function automatic void model_edge();
        edge_n++;
        if (rst) begin
            model_reset();
            return;
        end
        m_acc = load_valid && m_ready;
        for (int c = 0; c < CH; c++) begin
            if (m_acc && int'(load_channel) == c) begin
                m_term[c] = int'(load_value);
                m_os[c]   = load_oneshot;
                m_cnt[c]  = 0;
                m_run[c]  = (load_value != 0);
            end else if (m_run[c] && enable[c]) begin
                if (m_cnt[c] + 1 == m_term[c]) begin
                    m_cnt[c] = 0;
                    for (int g = 0; g < NI; g++)
                        exp_str[g][edge_n + 1 + lat_of(g)][c] = 1'b1;
                    if (m_os[c]) m_run[c] = 1'b0;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
        end
        m_ready = !m_acc;
    endfunction

    function automatic logic [CH*W-1:0] m_count_flat();
        logic [CH*W-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) v[c*W +: W] = W'(m_cnt[c]);
        return v;
    endfunction

    function automatic logic [CH-1:0] m_active();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_run[c];
        return v;
    endfunction

    task automatic compare();
        for (int g = 0; g < NI; g++) begin
            check($sformatf("load_ready[L%0d]", lat_of(g)), ready_o[g], m_ready);
            check($sformatf("active[L%0d]", lat_of(g)), active_o[g], m_active());
            check($sformatf("count[L%0d]", lat_of(g)), count_o[g], m_count_flat());
            check($sformatf("strobe[L%0d]", lat_of(g)), strobe_o[g], exp_str[g][edge_n]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (edge_n >= MAXE - 8) begin
            $display("FAIL edge_budget: got %0d edges, limit %0d", edge_n, MAXE - 8);
            $fatal(1, "edge budget exhausted");
        end
        model_edge();
        #1;
        compare();
    endtask

    task automatic do_load(input int c, input int val, input bit os);
        load_valid   = 1'b1;
        load_channel = CW'(c);
        load_value   = W'(val);
        load_oneshot = os;
        for (int i = 0; i < 4; i++) begin
            step();
            if (m_acc) break;
        end
        load_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int v;
        rst          = 1'b1;
        enable       = '0;
        load_valid   = 1'b0;
        load_channel = '0;
        load_value   = '0;
        load_oneshot = 1'b0;
        edge_n       = 0;
        model_reset();
        #1;
        compare();
        step();
        step();
        rst = 1'b0;
        repeat (3) step();

        // Periodic terminal 5 with enable held: four pulses over 22 enabled edges.
        do_load(0, 5, 0);
        enable = 5'b00001;
        n = 0;
        repeat (22) begin
            step();
            n += int'(strobe_o[0][0]);
        end
        check("periodic5_pulses", n, 4);

        // One-shot terminal 3 with enable toggling, then enable ignored in IDLE.
        do_load(1, 3, 1);
        for (int i = 0; i < 5; i++) begin
            enable[1] = (i % 2 == 0);
            step();
        end
        enable[1] = 1'b1;
        repeat (8) step();
        check("oneshot_idle", active_o[0][1], 1'b0);
        enable[1] = 1'b0;

        // Terminal 1 periodic: continuous strobes.
        do_load(2, 1, 0);
        enable[2] = 1'b1;
        repeat (10) step();
        check("term1_strobe_l2", strobe_o[1][2], 1'b1);

        // Reload on the terminal-event cycle: load wins, no strobe.
        do_load(0, 6, 0);
        for (int i = 0; i < 12 && m_cnt[0] != 5; i++) step();
        do_load(0, 4, 0);
        check("reload_count", count_o[0][W-1:0], 8'd0);
        repeat (10) step();

        // Back-to-back loads stall one cycle; out-of-range index is ignored.
        do_load(2, 7, 0);
        check("load_stall", ready_o[0], 1'b0);
        do_load(3, 9, 1);
        do_load(6, 3, 0);
        enable = '1;
        repeat (12) step();

        // Reset mid-count with strobes in flight.
        do_load(4, 1, 0);
        repeat (3) step();
        pulse_reset();
        repeat (8) step();
        check("post_reset_strobe_l3", strobe_o[2], 5'b0);

        // Largest terminal value.
        do_load(3, 255, 0);
        enable = 5'b01000;
        repeat (260) step();

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            enable = CH'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0:       v = 0;
                    1:       v = 1;
                    2:       v = 2;
                    3:       v = 255;
                    default: v = $urandom_range(3, 12);
                endcase
                load_valid   = 1'b1;
                load_channel = CW'($urandom_range(0, 7));
                load_value   = W'(v);
                load_oneshot = 1'($urandom_range(0, 1));
            end else begin
                load_valid = 1'b0;
            end
            step();
            if ($urandom_range(0, 199) == 0) begin
                load_valid = 1'b0;
                pulse_reset();
            end
        end
        load_valid = 1'b0;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
